stream_downsizer: RTL

//  Width converter from one wide stream word to SCALE narrow beats; inverse of stream_upsizer.

---
 rtl/stream_utils_pkg.sv | 37 +++
 rtl/stream_downsizer.sv | 111 +++++++++++
 2 files changed

// File: rtl/stream_utils_pkg.sv
// -----------------------------------------------------------------------------
// stream_utils_pkg
//  Shared helpers for the stream width converters (stream_upsizer and
//  stream_downsizer).
//  - clog2()         : ceiling log2 usable in constant expressions
//  - beat_idx_width(): width of a beat counter for a given SCALE, never below 1
//  - `STREAM_HANDSHAKE(valid, ready): a beat or word transfers on a clock edge
//    only when valid and ready are both high on that edge
// -----------------------------------------------------------------------------
`ifndef STREAM_UTILS_PKG_SV
`define STREAM_UTILS_PKG_SV

`define STREAM_HANDSHAKE(valid, ready) ((valid) & (ready))

package stream_utils_pkg;

  // Ceiling log2; clog2(1) == 0, clog2(3) == 2, clog2(4) == 2.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // A counter over SCALE beats still needs one bit when SCALE is 1.
  function automatic int beat_idx_width(input int scale);
    return (scale <= 1) ? 1 : clog2(scale);
  endfunction

endpackage

`endif

// File: rtl/stream_downsizer.sv
// -----------------------------------------------------------------------------
// stream_downsizer
//  Splits one wide word of DW_OUT*SCALE bits into SCALE narrow beats of DW_OUT
//  bits, least-significant slice first. Inverse of stream_upsizer.
//
//  Optional feature macro: STREAM_DOWNSIZER_LAST_EN
//    defined     -> port m_last_o marks the final beat of each word
//    not defined -> no m_last_o port and no extra logic
//
//  Parameters
//    DW_OUT : width of one output beat
//    SCALE  : output beats per input word (1..256)
//
//  Ports
//    clk       : clock, rising edge
//    rst       : synchronous reset, active-high
//    s_data_i  : wide input word
//    s_valid_i : input word valid
//    s_ready_o : block can take an input word this cycle
//    m_data_o  : current output beat
//    m_valid_o : output beat valid
//    m_ready_i : consumer accepts the beat this cycle
//    m_last_o  : final beat of a word (only with STREAM_DOWNSIZER_LAST_EN)
// -----------------------------------------------------------------------------
module stream_downsizer
  import stream_utils_pkg::*;
#(
  parameter int DW_OUT = 16,
  parameter int SCALE  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW_OUT*SCALE-1:0] s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [DW_OUT-1:0]       m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
`ifdef STREAM_DOWNSIZER_LAST_EN
  ,
  output logic                    m_last_o
`endif
);

  localparam int DW_IN = DW_OUT * SCALE;
  localparam int IW    = beat_idx_width(SCALE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SCALE - 1);

  logic [DW_IN-1:0] data_r;
  logic [IW-1:0]    idx_r;
  logic             full_r;

  logic on_last;
  logic in_fire;
  logic out_fire;

  assign on_last = (idx_r == LAST_IDX);

  // Reset forces both handshake outputs low even before full_r has been
  // cleared, so nothing is offered or accepted while rst is high.
  assign m_valid_o = full_r & ~rst;

  // A new word may load on the same edge the last beat leaves; that is what
  // keeps one beat per cycle across word boundaries.
  assign s_ready_o = ~rst & (~full_r | (on_last & m_ready_i));

  assign in_fire  = `STREAM_HANDSHAKE(s_valid_i, s_ready_o);
  assign out_fire = `STREAM_HANDSHAKE(m_valid_o, m_ready_i);

`ifdef STREAM_DOWNSIZER_LAST_EN
  assign m_last_o = m_valid_o & on_last;
`endif

  // Beat select: explicit compare per slice keeps index widths exact and
  // never addresses past the top slice for non-power-of-two SCALE.
  always_comb begin
    m_data_o = data_r[DW_OUT-1:0];
    for (int i = 1; i < SCALE; i++) begin
      if (idx_r == IW'(i)) begin
        m_data_o = data_r[i*DW_OUT +: DW_OUT];
      end
    end
  end

  // Control state. An input load takes priority over retiring the last beat,
  // so full_r stays high when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r <= 1'b0;
      idx_r  <= '0;
    end else if (in_fire) begin
      full_r <= 1'b1;
      idx_r  <= '0;
    end else if (out_fire) begin
      if (on_last) begin
        full_r <= 1'b0;
        idx_r  <= '0;
      end else begin
        idx_r <= idx_r + 1'b1;
      end
    end
  end

  // The word buffer carries no reset; it is only observed while full_r is set.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_r <= s_data_i;
    end
  end

endmodule
